// File: rtl/seq_div.sv
// Iterative unsigned restoring divider resolving BPC quotient bits per clock,
// with a ready/valid operand handshake and a one-cycle divide-by-zero path.
module seq_div #(
  parameter int A_BW = 8,
  parameter int B_BW = 5,
  parameter int BPC  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_in_valid,
  input  logic [A_BW-1:0] i_a,
  input  logic [B_BW-1:0] i_b,
  output logic            o_in_ready,
  output logic [A_BW-1:0] o_q,
  output logic [B_BW-1:0] o_r,
  output logic            o_out_valid,
  output logic            o_div_zero,
  output logic [50:0]     number
);

  // state | meaning
  // IDLE  | waiting for operands, ready high
  // CALC  | K iterations in progress, ready low
  // DONE  | result strobe cycle, ready high for back-to-back accept
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  localparam int K  = A_BW / BPC;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] K_LAST = CW'(K - 1);

  // Cell model: async-reset DFF 24T, full subtractor 28T, 2:1 mux 12T.
  localparam int N_FF     = 2 + A_BW + B_BW + (B_BW + 1) + CW + A_BW + B_BW + 2;
  localparam int N_STAGE  = BPC * (B_BW + 1);
  localparam int TR_TOTAL = 24 * N_FF + 28 * N_STAGE + 12 * N_STAGE;

  state_t            state_q;
  logic [A_BW-1:0]   a_q;
  logic [B_BW-1:0]   b_q;
  logic [B_BW:0]     rem_q;
  logic [CW-1:0]     cnt_q;
  logic [A_BW-1:0]   q_q;
  logic [B_BW-1:0]   r_q;
  logic              vld_q;
  logic              dz_q;

  logic [B_BW:0]     rem_s [0:BPC];
  logic [A_BW-1:0]   a_s   [0:BPC];
  logic [B_BW:0]     sh;
  logic [B_BW+1:0]   diff;
  logic [B_BW:0]     rem_d;
  logic [A_BW-1:0]   a_d;
  logic              accept;

  assign o_in_ready  = (state_q != S_CALC);
  assign accept      = i_in_valid & o_in_ready;
  assign o_q         = q_q;
  assign o_r         = r_q;
  assign o_out_valid = vld_q;
  assign o_div_zero  = dz_q;
  assign number      = 51'(TR_TOTAL);

  // Cascade of BPC shift/trial-subtract stages; the dividend register
  // fills with quotient bits from the LSB as its MSBs are consumed.
  always_comb begin
    sh   = '0;
    diff = '0;
    rem_s[0] = rem_q;
    a_s[0]   = a_q;
    for (int i = 0; i < BPC; i++) begin
      sh   = {rem_s[i][B_BW-1:0], a_s[i][A_BW-1]};
      diff = {1'b0, sh} - {2'b00, b_q};
      if (diff[B_BW+1]) begin
        rem_s[i+1] = sh;
        a_s[i+1]   = {a_s[i][A_BW-2:0], 1'b0};
      end else begin
        rem_s[i+1] = diff[B_BW:0];
        a_s[i+1]   = {a_s[i][A_BW-2:0], 1'b1};
      end
    end
    rem_d = rem_s[BPC];
    a_d   = a_s[BPC];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      vld_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            a_q   <= i_a;
            b_q   <= i_b;
            rem_q <= '0;
            cnt_q <= '0;
            if (i_b == '0) begin
              q_q     <= '1;
              r_q     <= i_a[B_BW-1:0];
              dz_q    <= 1'b1;
              vld_q   <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_CALC;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_CALC: begin
          a_q   <= a_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == K_LAST) begin
            q_q     <= a_d;
            r_q     <= rem_d[B_BW-1:0];
            dz_q    <= 1'b0;
            vld_q   <= 1'b1;
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
